// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, waits for a settled lock and tracks loss-of-lock events
module pll_lock_supervisor #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 50000,
  parameter int TIMEOUT     = 500000,
  parameter int PULSE       = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       clear,
  output logic       pll_rst,
  output logic       ready,
  output logic       sys_rst,
  output logic       lost,
  output logic [7:0] relocks,
  output logic [1:0] state
);
  localparam int MAXA = SETTLE > TIMEOUT ? SETTLE : TIMEOUT;
  localparam int MAXC = MAXA > PULSE ? MAXA : PULSE;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {PLLRST = 2'd0, WAIT = 2'd1, SETL = 2'd2, RUN = 2'd3} state_t;
  state_t                 st;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lk_s;
  assign lk_s    = sync[SYNC_STAGES-1];
  assign pll_rst = st == PLLRST;
  assign ready   = st == RUN;
  assign sys_rst = ~ready;
  assign state   = st;
  // locked is asynchronous to refclk; only the last stage feeds the FSM
  always_ff @(posedge refclk or posedge rst)
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], locked};
  // state machine with one shared counter, cleared on every transition; a loss overrides a coincident clear
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      st      <= PLLRST;
      cnt     <= '0;
      lost    <= 1'b0;
      relocks <= 8'd0;
    end else begin
      if (clear) begin
        lost    <= 1'b0;
        relocks <= 8'd0;
      end
      case (st)
        PLLRST:
          if (cnt == CW'(PULSE - 1)) begin
            st  <= WAIT;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        WAIT:
          if (lk_s) begin
            st  <= SETL;
            cnt <= '0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            st  <= PLLRST;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        SETL:
          if (!lk_s) begin
            st  <= WAIT;
            cnt <= '0;
          end else if (cnt == CW'(SETTLE - 1)) begin
            st  <= RUN;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        default:
          if (!lk_s) begin
            st      <= WAIT;
            cnt     <= '0;
            lost    <= 1'b1;
            relocks <= clear ? 8'd1 : (relocks == 8'd255 ? 8'd255 : relocks + 8'd1);
          end
      endcase
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of reset sequencing, lock settle, loss tracking and async reset
module tb_pll_lock_supervisor;
  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       clear = 1'b0;
  logic       pll_rst, ready, sys_rst, lost;
  logic [7:0] relocks;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(.SYNC_STAGES(2), .SETTLE(8), .TIMEOUT(32), .PULSE(4)) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .clear(clear),
    .pll_rst(pll_rst), .ready(ready), .sys_rst(sys_rst),
    .lost(lost), .relocks(relocks), .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_lost", lost, 0);
    chk("rst_relocks", relocks, 0);
    // scenario 1: no lock, pulse / timeout / pulse
    do_reset();
    step(3);
    chk("s1_e3_state", state, 0);
    step(1);
    chk("s1_e4_state", state, 1);
    chk("s1_e4_pll_rst", pll_rst, 0);
    step(31);
    chk("s1_e35_state", state, 1);
    step(1);
    chk("s1_e36_state", state, 0);
    chk("s1_e36_pll_rst", pll_rst, 1);
    step(3);
    chk("s1_e39_state", state, 0);
    step(1);
    chk("s1_e40_state", state, 1);
    chk("s1_ready", ready, 0);
    // scenario 2: locked first sampled high at edge 10
    do_reset();
    step(9);
    locked = 1'b1;
    step(2);
    chk("s2_e11_state", state, 1);
    step(1);
    chk("s2_e12_state", state, 2);
    step(7);
    chk("s2_e19_ready", ready, 0);
    chk("s2_e19_state", state, 2);
    step(1);
    chk("s2_e20_ready", ready, 1);
    chk("s2_e20_sys_rst", sys_rst, 0);
    chk("s2_e20_state", state, 3);
    chk("s2_lost", lost, 0);
    // scenario 3: locked low at edges 21..23
    locked = 1'b0;
    step(2);
    chk("s3_e22_ready", ready, 1);
    step(1);
    chk("s3_e23_ready", ready, 0);
    chk("s3_e23_state", state, 1);
    chk("s3_lost", lost, 1);
    chk("s3_relocks", relocks, 1);
    locked = 1'b1;
    step(2);
    chk("s3_e25_state", state, 1);
    step(1);
    chk("s3_e26_state", state, 2);
    step(7);
    chk("s3_e33_ready", ready, 0);
    step(1);
    chk("s3_e34_ready", ready, 1);
    // scenario 4: second loss, then a one-cycle glitch while settling at cnt=5
    locked = 1'b0;
    step(2);
    chk("s4_e36_ready", ready, 1);
    step(1);
    chk("s4_e37_relocks", relocks, 2);
    locked = 1'b1;
    step(3);
    chk("s4_e40_state", state, 2);
    step(3);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    chk("s4_e45_state", state, 2);
    step(1);
    chk("s4_e46_state", state, 1);
    chk("s4_e46_relocks", relocks, 2);
    step(1);
    chk("s4_e47_state", state, 2);
    step(7);
    chk("s4_e54_state", state, 2);
    step(1);
    chk("s4_e55_state", state, 3);
    chk("s4_relocks", relocks, 2);
    // scenario 5: 298 more losses from RUN saturate the counter
    for (int i = 0; i < 298; i++) begin
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(11);
      if (i == 252) chk("s5_relocks_255", relocks, 255);
    end
    chk("s5_state_run", state, 3);
    chk("s5_relocks_sat", relocks, 255);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("s5_clr_loss_relocks", relocks, 1);
    chk("s5_clr_loss_lost", lost, 1);
    chk("s5_clr_loss_state", state, 1);
    step(9);
    chk("s5_run_again", state, 3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("s5_clr_relocks", relocks, 0);
    chk("s5_clr_lost", lost, 0);
    chk("s5_clr_state", state, 3);
    // scenario 6: asynchronous reset between edges while in RUN
    #3;
    rst = 1'b1;
    #1;
    chk("s6_ready", ready, 0);
    chk("s6_pll_rst", pll_rst, 1);
    chk("s6_state", state, 0);
    chk("s6_sys_rst", sys_rst, 1);
    #2;
    rst = 1'b0;
    step(3);
    chk("s6_e3_state", state, 0);
    step(1);
    chk("s6_e4_state", state, 1);
    step(1);
    chk("s6_e5_state", state, 2);
    step(7);
    chk("s6_e12_ready", ready, 0);
    step(1);
    chk("s6_e13_ready", ready, 1);
    chk("s6_relocks", relocks, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
